// File: rtl/event_replayer.sv
// event_replayer: replays a loaded table of timed per-channel events to a monitor.
// Optional EVENT_REPLAYER_LOOP_EN adds a loop input that restarts playback from DONE.
module event_replayer #(
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = 64,
  parameter int DELAY_W = 32,
  parameter int DEPTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [DELAY_W-1:0]       ld_delay,
  input  logic [NUM_CH-1:0]        ld_mask,
  input  logic [NUM_CH*DATA_W-1:0] ld_data,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     clear,
  input  logic                     hold,
`ifdef EVENT_REPLAYER_LOOP_EN
  input  logic                     loop,
`endif
  output logic [NUM_CH*DATA_W-1:0] input_data,
  output logic [NUM_CH-1:0]        new_input,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              evt_cnt
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, FIRE, DONE} state_t;
  state_t state;
  logic [AW:0] cnt;
  logic [AW-1:0] idx, nidx;
  logic [DELAY_W-1:0] dcnt;
  logic [DELAY_W-1:0] delay_mem [DEPTH];
  logic [NUM_CH-1:0] mask_mem [DEPTH];
  logic [NUM_CH*DATA_W-1:0] data_mem [DEPTH];
  logic [NUM_CH*DATA_W-1:0] fire_data;
  logic ld_acc, last, loop_go;
`ifdef EVENT_REPLAYER_LOOP_EN
  assign loop_go = loop;
`else
  assign loop_go = 1'b0;
`endif
  // cnt[AW] set means the table holds DEPTH entries (DEPTH is a power of two)
  assign ld_ready = state == IDLE && !cnt[AW] && !clear;
  assign ld_acc = ld_valid && ld_ready && en;
  assign nidx = idx + 1'b1;
  assign last = {1'b0, idx} == cnt - 1'b1;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    assign fire_data[i*DATA_W +: DATA_W] = mask_mem[idx][i] ? data_mem[idx][i*DATA_W +: DATA_W] : '0;
  end
  always_ff @(posedge clk) begin
    if (ld_acc) begin
      delay_mem[cnt[AW-1:0]] <= ld_delay;
      mask_mem[cnt[AW-1:0]] <= ld_mask;
      data_mem[cnt[AW-1:0]] <= ld_data;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      dcnt <= '0;
      evt_cnt <= '0;
      new_input <= '0;
      input_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (en) begin
      new_input <= '0;
      input_data <= '0;
      done <= 1'b0;
      if (state == IDLE && clear) cnt <= '0;
      else if (ld_acc) cnt <= cnt + 1'b1;
      if (abort) begin
        state <= IDLE;
        busy <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start && !clear && cnt != '0) begin
            state <= WAIT;
            idx <= '0;
            dcnt <= delay_mem[AW'(0)];
            evt_cnt <= '0;
            busy <= 1'b1;
          end
          WAIT: if (!hold) begin
            if (dcnt == '0) begin
              state <= FIRE;
              new_input <= mask_mem[idx];
              input_data <= fire_data;
              evt_cnt <= &evt_cnt ? evt_cnt : evt_cnt + 16'd1;
            end else dcnt <= dcnt - 1'b1;
          end
          FIRE: if (last) begin
            state <= DONE;
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            state <= WAIT;
            idx <= nidx;
            dcnt <= delay_mem[nidx];
          end
          DONE: if (loop_go) begin
            state <= WAIT;
            idx <= '0;
            dcnt <= delay_mem[AW'(0)];
            busy <= 1'b1;
          end else state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_event_replayer.sv
// tb_event_replayer: scoreboard bench for event_replayer (expected pulses/done queued at start).
module tb_event_replayer;
  localparam int DEPTH = 16;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, ld_valid = 1'b0, ld_ready;
  logic [31:0] ld_delay = '0;
  logic [1:0] ld_mask = '0, new_input;
  logic [127:0] ld_data = '0, input_data;
  logic start = 1'b0, abort = 1'b0, clear = 1'b0, hold = 1'b0, busy, done;
  logic [15:0] evt_cnt;
`ifdef EVENT_REPLAYER_LOOP_EN
  logic loop_s = 1'b0;
`endif
  typedef struct {int t; logic [1:0] m; logic [127:0] d;} pulse_t;
  pulse_t pq[$];
  pulse_t mon_e;
  int dq[$];
  int md[$];
  logic [1:0] mm[$];
  logic [127:0] mdat[$];
  int compared = 0, mismatched = 0, cyc = 0, mon_d;

  event_replayer dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_delay(ld_delay), .ld_mask(ld_mask), .ld_data(ld_data),
    .start(start), .abort(abort), .clear(clear), .hold(hold),
`ifdef EVENT_REPLAYER_LOOP_EN
    .loop(loop_s),
`endif
    .input_data(input_data), .new_input(new_input), .busy(busy), .done(done), .evt_cnt(evt_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] exp_data(input logic [1:0] m, input logic [127:0] d);
    return {m[1] ? d[127:64] : 64'd0, m[0] ? d[63:0] : 64'd0};
  endfunction

  always @(negedge clk) begin
    compared++;
    if (new_input !== 2'b00) begin
      if (pq.size() == 0) begin
        mismatched++;
        $display("FAIL pulse_unexpected: cycle %0d new_input=%b, required no pulse", cyc, new_input);
      end else begin
        mon_e = pq.pop_front();
        if (cyc !== mon_e.t || new_input !== mon_e.m || input_data !== mon_e.d) begin
          mismatched++;
          $display("FAIL pulse: got cycle %0d mask %b data %h, required cycle %0d mask %b data %h",
                   cyc, new_input, input_data, mon_e.t, mon_e.m, mon_e.d);
        end
      end
    end else if (input_data !== '0) begin
      mismatched++;
      $display("FAIL idle_data: cycle %0d input_data=%h, required 0", cyc, input_data);
    end
    if (done !== 1'b0) begin
      compared++;
      if (dq.size() == 0) begin
        mismatched++;
        $display("FAIL done_unexpected: cycle %0d done=%b, required 0", cyc, done);
      end else begin
        mon_d = dq.pop_front();
        if (cyc !== mon_d) begin
          mismatched++;
          $display("FAIL done_cycle: got %0d, required %0d", cyc, mon_d);
        end
      end
    end
  end

  task automatic load(input int d, input logic [1:0] m, input logic [127:0] dat);
    bit exp_rdy;
    exp_rdy = md.size() < DEPTH;
    ld_valid = 1'b1; ld_delay = d; ld_mask = m; ld_data = dat;
    #1;
    compared++;
    if (ld_ready !== exp_rdy) begin
      mismatched++;
      $display("FAIL ld_ready: got %b, required %b (entries %0d)", ld_ready, exp_rdy, md.size());
    end
    @(negedge clk);
    ld_valid = 1'b0;
    if (exp_rdy) begin md.push_back(d); mm.push_back(m); mdat.push_back(dat); end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    #1;
    compared++;
    if (ld_ready !== 1'b0) begin mismatched++; $display("FAIL ld_ready_during_clear: got %b, required 0", ld_ready); end
    @(negedge clk);
    clear = 1'b0;
    #1;
    compared++;
    if (ld_ready !== 1'b1) begin mismatched++; $display("FAIL ld_ready_after_clear: got %b, required 1", ld_ready); end
    md.delete(); mm.delete(); mdat.delete();
  endtask

  task automatic play(input int hold_from, input int hold_len, input int abort_at, input int passes);
    int c, t, last_t, n, k, dlast;
    bit timed_out;
    n = md.size(); c = cyc; t = c + 2 + md[0] + hold_len; last_t = t; dlast = 0; timed_out = 1'b1;
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < n; i++) begin
        if (abort_at < 0 || t <= c + abort_at) pq.push_back('{t, mm[i], exp_data(mm[i], mdat[i])});
        last_t = t;
        if (i < n - 1) t += md[i+1] + 2;
      end
      dlast = last_t + 1;
      if (abort_at < 0 || dlast <= c + abort_at) dq.push_back(dlast);
      t = dlast + 2 + md[0];
    end
    start = 1'b1;
    for (k = 1; k < 3000; k++) begin
      @(negedge clk);
      start = 1'b0;
      hold = k >= hold_from && k < hold_from + hold_len;
      abort = k == abort_at;
`ifdef EVENT_REPLAYER_LOOP_EN
      loop_s = passes > 1 && cyc < dlast;
`endif
      if (abort_at >= 0 && k == abort_at + 1) begin
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL busy_after_abort: got %b, required 0", busy); end
      end
      if (pq.size() == 0 && dq.size() == 0 && k > abort_at + 20) begin timed_out = 1'b0; break; end
    end
    hold = 1'b0; abort = 1'b0;
`ifdef EVENT_REPLAYER_LOOP_EN
    loop_s = 1'b0;
`endif
    compared++;
    if (timed_out) begin
      mismatched++;
      $display("FAIL timeout: %0d pulses and %0d dones still pending, required 0", pq.size(), dq.size());
      pq.delete(); dq.delete();
    end
    if (abort_at < 0) begin
      compared++;
      if (evt_cnt !== 16'(n * passes) || busy !== 1'b0) begin
        mismatched++;
        $display("FAIL evt_cnt: got %0d busy %b, required %0d busy 0", evt_cnt, busy, n * passes);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    compared++;
    if (busy !== 1'b0 || done !== 1'b0 || evt_cnt !== 16'd0 || new_input !== 2'b00 || input_data !== '0 || ld_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_state: busy %b done %b evt_cnt %0d new_input %b ld_ready %b, required 0 0 0 00 1",
               busy, done, evt_cnt, new_input, ld_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    load(0, 2'b11, {64'd1, 64'd1});
    load(6, 2'b11, {64'd2, 64'd2});
    play(0, 0, -1, 1);
  endtask

  task automatic test_lane_mask();
    do_clear();
    load(1, 2'b01, {64'hDEAD_BEEF_0000_0001, 64'd2});
    play(0, 0, -1, 1);
  endtask

  task automatic test_hold();
    do_clear();
    load(4, 2'b11, {64'h55, 64'hAA});
    play(2, 3, -1, 1);
  endtask

  task automatic test_full();
    do_clear();
    for (int i = 0; i < DEPTH; i++) load(i % 3, 2'((i % 3) + 1), {64'(i), ~64'(i)});
    compared++;
    if (ld_ready !== 1'b0) begin mismatched++; $display("FAIL ld_ready_full: got %b, required 0", ld_ready); end
    load(0, 2'b11, {128{1'b1}});
    play(0, 0, -1, 1);
    do_clear();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL start_empty: busy %b, required 0", busy); end
  endtask

  task automatic test_abort();
    do_clear();
    load(1, 2'b01, {64'h0, 64'h11});
    load(5, 2'b10, {64'h22, 64'h0});
    load(2, 2'b11, {64'h33, 64'h44});
    play(0, 0, 6, 1);
    play(0, 0, -1, 1);
  endtask

  task automatic test_reset_mid();
    do_clear();
    load(3, 2'b11, {64'h66, 64'h77});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if (busy !== 1'b0 || evt_cnt !== 16'd0) begin
      mismatched++;
      $display("FAIL async_reset: busy %b evt_cnt %0d, required 0 0", busy, evt_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    md.delete(); mm.delete(); mdat.delete();
    repeat (12) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL table_after_reset: busy %b, required 0", busy); end
  endtask

`ifdef EVENT_REPLAYER_LOOP_EN
  task automatic test_loop();
    do_clear();
    load(1, 2'b01, {64'h0, 64'h5});
    load(3, 2'b10, {64'h9, 64'h0});
    play(0, 0, -1, 3);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_lane_mask();
    test_hold();
    test_full();
    test_abort();
    test_reset_mid();
`ifdef EVENT_REPLAYER_LOOP_EN
    test_loop();
`endif
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/event_replayer.md
EVENT_REPLAYER -- requirements
Module: event_replayer

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of monitor input streams driven.
REQ-002 SHALL have parameter DATA_W, default 64, width of each stream value.
REQ-003 SHALL have parameter DELAY_W, default 32, width of the inter-event delay field.
REQ-004 SHALL have parameter DEPTH, default 16, number of event table entries (power of two, >=2).
REQ-005 SHALL have port clk  in  1  single clock; all logic on the rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port en  in  1  global enable; when 0, all state and outputs hold.
REQ-008 SHALL have port ld_valid / ld_ready  in / out  1 / 1  event-table load handshake.
REQ-009 SHALL have port ld_delay  in  DELAY_W  wait cycles before the loaded event.
REQ-010 SHALL have port ld_mask  in  NUM_CH  per-channel new-value flags of the loaded event.
REQ-011 SHALL have port ld_data  in  NUM_CH*DATA_W  per-channel values; channel i at bits [i*DATA_W +: DATA_W].
REQ-012 SHALL have ports start, abort, clear, hold  in  1 each  playback control; hold = downstream backpressure.
REQ-013 SHALL have ports input_data  out  NUM_CH*DATA_W  and new_input  out  NUM_CH  replayed event to the monitor.
REQ-014 SHALL have ports busy, done  out  1 each  and evt_cnt  out  16  fired-event count.

Function
REQ-015 SHALL store events in a table with write count cnt (0..DEPTH); playback reads without consuming, so the table is replayable.
REQ-016 SHALL use states IDLE, WAIT, FIRE, DONE; busy = 1 in WAIT and FIRE.
REQ-017 SHALL drive ld_ready = 1 only in IDLE with cnt < DEPTH and clear = 0; a load is accepted on ld_valid && ld_ready && en, and cnt increments.
REQ-018 SHALL set cnt to 0 when clear = 1 in IDLE; clear outside IDLE is ignored.
REQ-019 SHALL on start in IDLE with cnt > 0 go to WAIT with idx = 0, dcnt = delay[0], evt_cnt = 0; start with cnt = 0 is ignored.
REQ-020 SHALL in WAIT decrement dcnt when hold = 0; go to FIRE when dcnt == 0 and hold = 0; with hold = 1, freeze dcnt and stay in WAIT.
REQ-021 SHALL in FIRE assert new_input = mask[idx] and input_data = data[idx] for exactly that cycle, with masked-off lanes driven 0; evt_cnt increments, saturating at 16'hFFFF.
REQ-022 SHALL leave FIRE for WAIT with idx+1 and that entry's delay, or for DONE if idx == cnt-1; pulse spacing is delay+2 cycles, first pulse start+2+delay[0].
REQ-023 SHALL in DONE assert done for one cycle, then go to IDLE.
REQ-024 SHALL hold new_input = 0 and input_data = 0 in every state other than FIRE.
REQ-025 SHALL on abort go to IDLE next cycle from any state with outputs zeroed and the table retained; abort takes priority over start.

Reset
REQ-026 SHALL on rst_n = 0 set state IDLE, cnt 0, idx 0, dcnt 0, evt_cnt 0, and new_input, input_data, busy, done to 0, asynchronously.
REQ-027 SHALL on reset during playback return to IDLE immediately, with no further pulse and table contents discarded (cnt = 0).

Configuration
REQ-028 SHALL with macro EVENT_REPLAYER_LOOP_EN defined add input port loop (1 bit); in DONE with loop = 1, done still pulses and the next state is WAIT with idx = 0, dcnt = delay[0], and evt_cnt not cleared.
REQ-029 SHALL without EVENT_REPLAYER_LOOP_EN have no loop port and always go from DONE to IDLE.

Verification
REQ-030 SHALL verify: load (d=0,m=11,1/1), (d=6,m=11,2/2); start at cycle 10 -> new_input=11 at cycles 12 and 20, done at 21, evt_cnt=2.
REQ-031 SHALL verify: event m=01 value 2 -> new_input=01, lane0=2, lane1=0 for one cycle.
REQ-032 SHALL verify: delay 4 with hold high for 3 cycles mid-wait -> pulse delayed by exactly 3 cycles.
REQ-033 SHALL verify: load DEPTH entries -> ld_ready=0; extra ld_valid not accepted; clear -> cnt=0, ld_ready=1.
REQ-034 SHALL verify: abort during WAIT of event 2 of 3 -> IDLE next cycle, no further pulses; restart replays all 3 events.
REQ-035 SHALL verify: with EVENT_REPLAYER_LOOP_EN and loop=1, 2 events, 3 passes -> 6 pulses, done pulsed 3 times, evt_cnt=6.
